uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_picker.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Provides the arbiter FSM state type and the default requester count.
package uart_pkg;

   localparam int UART_ARB_N_REQ_DEFAULT = 4;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_LAUNCH    = 2'd1,
      ARB_WAIT_BUSY = 2'd2,
      ARB_WAIT_DONE = 2'd3
   } ARB_STATES;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART-transmitter bus of the arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]      req;
   logic [N_REQ-1:0][7:0] req_data;
   logic [N_REQ-1:0]      gnt;
   logic [7:0]            tx_data;
   logic                  tx_start;
   logic                  tx_en_l;
   logic [IDX_W-1:0]      owner;
   logic                  busy;

   modport master (
      output req, req_data, tx_en_l,
      input  gnt, tx_data, tx_start, owner, busy
   );

   modport slave (
      input  req, req_data, tx_en_l,
      output gnt, tx_data, tx_start, owner, busy
   );

endinterface

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational winner select: first asserted request found when searching
// upward from ptr (wrapping), returned both as one-hot and as an index.
module uart_arb_picker #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   int               pos_s;
   logic [IDX_W-1:0] sel_s;

   // Rotating search; ptr tied to zero gives plain lowest-index priority
   always_comb begin
      valid  = 1'b0;
      idx    = {IDX_W{1'b0}};
      onehot = {N_REQ{1'b0}};
      pos_s  = 0;
      sel_s  = {IDX_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         pos_s = int'(ptr) + i;
         if (pos_s >= N_REQ) begin
            pos_s = pos_s - N_REQ;
         end else begin
            pos_s = pos_s;
         end
         sel_s = IDX_W'(pos_s);
         if (!valid && req[sel_s]) begin
            valid = 1'b1;
            idx   = sel_s;
         end else begin
            valid = valid;
         end
      end
      onehot[idx] = valid;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte requesters onto one external UART transmitter.
// Define UART_ARB_RR_EN for round-robin; otherwise lowest index wins.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = UART_ARB_N_REQ_DEFAULT
) (
   input logic            clk,
   input logic            rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);

   ARB_STATES        state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic             busy_q, busy_d;

   logic [N_REQ-1:0] pick_onehot_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             pick_valid_s;
   logic [IDX_W-1:0] ptr_s;
   logic             grant_s;

   assign grant_s = (state_q == ARB_IDLE) && pick_valid_s && bus.tx_en_l;

`ifdef UART_ARB_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Search restarts just past the most recent winner
   always_comb begin
      ptr_d = ptr_q;
      if (grant_s) begin
         if (pick_idx_s == IDX_W'(N_REQ - 1)) begin
            ptr_d = {IDX_W{1'b0}};
         end else begin
            ptr_d = pick_idx_s + 1'b1;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= {IDX_W{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_s = ptr_q;
`else
   assign ptr_s = {IDX_W{1'b0}};
`endif

   uart_arb_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req    (bus.req),
      .ptr    (ptr_s),
      .onehot (pick_onehot_s),
      .idx    (pick_idx_s),
      .valid  (pick_valid_s)
   );

   // Next state and next registered outputs; outputs lag the state by one flop
   always_comb begin
      state_d    = state_q;
      gnt_d      = {N_REQ{1'b0}};
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      owner_d    = owner_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_s) begin
               gnt_d     = pick_onehot_s;
               tx_data_d = bus.req_data[pick_idx_s];
               owner_d   = pick_idx_s;
               state_d   = ARB_LAUNCH;
            end else begin
               state_d   = ARB_IDLE;
            end
         end
         ARB_LAUNCH: begin
            tx_start_d = 1'b1;
            state_d    = ARB_WAIT_BUSY;
         end
         ARB_WAIT_BUSY: begin
            if (!bus.tx_en_l) begin
               state_d = ARB_WAIT_DONE;
            end else begin
               state_d = ARB_WAIT_BUSY;
            end
         end
         ARB_WAIT_DONE: begin
            if (bus.tx_en_l) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_WAIT_DONE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
      busy_d = (state_d != ARB_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= {N_REQ{1'b0}};
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         owner_q    <= {IDX_W{1'b0}};
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.owner    = owner_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple behavioural UART transmitter.
// Expected grant order follows UART_ARB_RR_EN when it is defined.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int FRAME = 8;
`ifdef UART_ARB_RR_EN
   localparam int RR = 1;
`else
   localparam int RR = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic uart_en_l;
   logic ext_hold = 1'b0;
   int   fcnt;
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   int   last_rise_cyc = 0;
   int   last_start_cyc = 0;
   logic [7:0] rx_q[$];

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign bus.tx_en_l = uart_en_l & ~ext_hold;

   // Behavioural UART: captures the byte on tx_start, busy for FRAME cycles
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         uart_en_l <= 1'b1;
         fcnt      <= 0;
      end else if (fcnt == 0) begin
         if (bus.tx_start) begin
            uart_en_l <= 1'b0;
            fcnt      <= FRAME;
            rx_q.push_back(bus.tx_data);
         end
      end else begin
         if (fcnt == 1) uart_en_l <= 1'b1;
         fcnt <= fcnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for a grant, check it, then check the launch cycle that follows
   task automatic grant_start(input logic [3:0] exp_gnt, input logic [7:0] exp_byte,
                              input logic [1:0] exp_idx, input logic [3:0] drop,
                              input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while (bus.gnt == 4'b0000 && n < budget) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
      chk({tag, "_nostart_at_gnt"}, 32'(bus.tx_start), 32'd0);
      bus.req = bus.req & ~drop;
      @(negedge clk);
      last_start_cyc = cyc;
      chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
      chk({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
      chk({tag, "_data"}, 32'(bus.tx_data), 32'(exp_byte));
      chk({tag, "_owner"}, 32'(bus.owner), 32'(exp_idx));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
   endtask

   // Follow the frame to completion, checking hold and no-grant behaviour
   task automatic frame_end(input logic [7:0] exp_byte, input string tag);
      int   n = 0;
      logic bad_gnt = 1'b0;
      logic bad_data = 1'b0;
      logic seen_low = 1'b0;
      logic rise_done = 1'b0;
      logic [31:0] got;
      while (bus.busy && n < 200) begin
         if (bus.gnt != 4'b0000) bad_gnt = 1'b1;
         if (bus.tx_data != exp_byte) bad_data = 1'b1;
         if (!bus.tx_en_l) begin
            seen_low = 1'b1;
         end else if (seen_low && !rise_done) begin
            rise_done = 1'b1;
            last_rise_cyc = cyc;
         end
         n++;
         @(negedge clk);
      end
      chk({tag, "_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_uart_ran"}, 32'(seen_low), 32'd1);
      chk({tag, "_no_gnt_busy"}, 32'(bad_gnt), 32'd0);
      chk({tag, "_data_hold"}, 32'(bad_data), 32'd0);
      chk({tag, "_data_after"}, 32'(bus.tx_data), 32'(exp_byte));
      if (rx_q.size() > 0) got = 32'(rx_q.pop_front());
      else got = 32'hFFFF_FFFF;
      chk({tag, "_rx"}, got, 32'(exp_byte));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.req = 4'b0000;
      repeat (2) @(negedge clk);
      rx_q.delete();
      rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   order[5];
      logic bad;

      bus.req      = 4'b0000;
      bus.req_data = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_start", 32'(bus.tx_start), 32'd0);
      chk("rst_data", 32'(bus.tx_data), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b1;

      // single requester 2
      @(negedge clk);
      bus.req_data[2] = 8'hA5;
      bus.req[2] = 1'b1;
      grant_start(4'b0100, 8'hA5, 2'd2, 4'b0100, 200, "single");
      frame_end(8'hA5, "single");

      // all requesting, grant order from reset
      do_reset();
      for (int i = 0; i < 4; i++) bus.req_data[i] = 8'h10 + 8'(i);
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) order[k] = (RR != 0) ? (k % 4) : 0;
      for (int k = 0; k < 5; k++) begin
         grant_start(4'(1 << order[k]), 8'h10 + 8'(order[k]), 2'(order[k]),
                     (k == 4) ? 4'b1111 : 4'b0000, 200, $sformatf("all%0d", k));
         frame_end(8'h10 + 8'(order[k]), $sformatf("all%0d", k));
      end

      // request arriving during another frame
      bus.req_data[0] = 8'h3C;
      bus.req[0] = 1'b1;
      grant_start(4'b0001, 8'h3C, 2'd0, 4'b0001, 200, "late0");
      bus.req_data[1] = 8'hC3;
      bus.req[1] = 1'b1;
      frame_end(8'h3C, "late0");
      grant_start(4'b0010, 8'hC3, 2'd1, 4'b0010, 200, "late1");
      frame_end(8'hC3, "late1");

      // external UART user holds tx_en_l low
      ext_hold = 1'b1;
      bus.req_data[3] = 8'h5A;
      bus.req[3] = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.gnt != 4'b0000 || bus.busy) bad = 1'b1;
      end
      chk("hold_no_gnt", 32'(bad), 32'd0);
      ext_hold = 1'b0;
      grant_start(4'b1000, 8'h5A, 2'd3, 4'b1000, 0, "hold");
      frame_end(8'h5A, "hold");

      // reset in the middle of a frame
      bus.req_data[0] = 8'h77;
      bus.req[0] = 1'b1;
      grant_start(4'b0001, 8'h77, 2'd0, 4'b0001, 200, "midrst");
      repeat (3) @(negedge clk);
      chk("midrst_uart_busy", 32'(bus.tx_en_l), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("midrst_data", 32'(bus.tx_data), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_owner", 32'(bus.owner), 32'd0);
      chk("midrst_gnt", 32'(bus.gnt), 32'd0);
      chk("midrst_start", 32'(bus.tx_start), 32'd0);
      @(negedge clk);
      rx_q.delete();
      rst = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.tx_start || bus.gnt != 4'b0000) bad = 1'b1;
      end
      chk("midrst_quiet", 32'(bad), 32'd0);

      // back-to-back bytes from requester 0
      bus.req_data[0] = 8'h01;
      bus.req[0] = 1'b1;
      grant_start(4'b0001, 8'h01, 2'd0, 4'b0001, 200, "b2b1");
      bus.req_data[0] = 8'h02;
      bus.req[0] = 1'b1;
      frame_end(8'h01, "b2b1");
      grant_start(4'b0001, 8'h02, 2'd0, 4'b0001, 200, "b2b2");
      chk("b2b_gap", 32'((last_start_cyc - last_rise_cyc >= 2) &&
                         (last_start_cyc - last_rise_cyc <= 3)), 32'd1);
      frame_end(8'h02, "b2b2");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
